// File: rtl/fifo_pkg.sv
// Shared helpers for the dual-clock FIFO: Gray conversion and wrapped level arithmetic.
`timescale 1ns/100ps
package fifo_pkg;

   // Widest pointer supported (AW up to 13, plus the wrap bit)
   localparam int unsigned PTR_MAX_W = 14;

   typedef logic [PTR_MAX_W-1:0] ptr_t;

   // Narrower pointers are zero-extended into ptr_t; the upper bits then stay zero in both codes
   function automatic ptr_t bin2gray(input ptr_t b);
      return b ^ (b >> 1);
   endfunction

   function automatic ptr_t gray2bin(input ptr_t g);
      ptr_t b;
      b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
      for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   // (a - b) mod 2**w, for pointers that are w bits wide
   function automatic ptr_t level_calc(input ptr_t a, input ptr_t b, input int unsigned w);
      ptr_t mask;
      mask = ptr_t'((15'(1) << w) - 15'(1));
      return (a - b) & mask;
   endfunction

endpackage

// File: rtl/gray_sync.sv
// Multi-flop synchroniser for a Gray-coded pointer entering a new clock domain.
`timescale 1ns/100ps
module gray_sync #(
   parameter int unsigned WIDTH  = 4,
   parameter int unsigned STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] sync_q [STAGES];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(STAGES); i++) begin
            sync_q[i] <= '0;
         end
      end else begin
         sync_q[0] <= d;
         for (int i = 1; i < int'(STAGES); i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   assign q = sync_q[STAGES-1];

endmodule

// File: rtl/async_fifo_cfg.sv
// Dual-clock FIFO with Gray-coded pointer crossing, programmable almost flags,
// sticky overflow/underflow and a selectable FWFT or registered read port.
`timescale 1ns/100ps
module async_fifo_cfg
   import fifo_pkg::*;
#(
   parameter int unsigned DW          = 32,
   parameter int unsigned AW          = 3,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FWFT        = 1,
   parameter int unsigned AFULL_TH    = (2 ** AW) - 2,
   parameter int unsigned AEMPTY_TH   = 2
) (
   input  logic          wr_clk,
   input  logic          wr_reset_n,
   input  logic          rd_clk,
   input  logic          rd_reset_n,
   input  logic          wr_en,
   input  logic [DW-1:0] wr_data,
   output logic          full,
   output logic          afull,
   output logic [AW:0]   wr_level,
   output logic          overflow,
   input  logic          rd_en,
   output logic [DW-1:0] rd_data,
   output logic          empty,
   output logic          aempty,
   output logic [AW:0]   rd_level,
   output logic          underflow
);

   localparam int unsigned DEPTH = 2 ** AW;
   localparam int unsigned PW    = AW + 1;

   logic [DW-1:0] mem [DEPTH];

   // ---------------- write domain ----------------
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] wr_ptr_nxt;
   logic [PW-1:0] wr_gray;
   logic [PW-1:0] rd_gray_wsync;
   logic [PW-1:0] sync_rd_ptr;
   logic          wr_fire;

   assign wr_fire    = wr_en & ~full;
   assign wr_ptr_nxt = wr_ptr + PW'(1);

   always_ff @(posedge wr_clk or negedge wr_reset_n) begin
      if (!wr_reset_n) begin
         wr_ptr   <= '0;
         wr_gray  <= '0;
         overflow <= 1'b0;
      end else begin
         if (wr_fire) begin
            wr_ptr  <= wr_ptr_nxt;
            wr_gray <= PW'(bin2gray(ptr_t'(wr_ptr_nxt)));
         end
         if (wr_en && full) begin
            overflow <= 1'b1;
         end
      end
   end

   always_ff @(posedge wr_clk) begin
      if (wr_fire) begin
         mem[wr_ptr[AW-1:0]] <= wr_data;
      end
   end

   gray_sync #(.WIDTH(PW), .STAGES(SYNC_STAGES)) u_rd_ptr_sync (
      .clk   (wr_clk),
      .rst_n (wr_reset_n),
      .d     (rd_gray),
      .q     (rd_gray_wsync)
   );

   // Extra decode flop keeps the crossing at SYNC_STAGES+1 destination edges
   always_ff @(posedge wr_clk or negedge wr_reset_n) begin
      if (!wr_reset_n) begin
         sync_rd_ptr <= '0;
      end else begin
         sync_rd_ptr <= PW'(gray2bin(ptr_t'(rd_gray_wsync)));
      end
   end

   assign wr_level = PW'(level_calc(ptr_t'(wr_ptr), ptr_t'(sync_rd_ptr), PW));
   assign full     = (wr_level == PW'(DEPTH));
   assign afull    = (32'(wr_level) >= AFULL_TH);

   // ---------------- read domain ----------------
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] rd_ptr_nxt;
   logic [PW-1:0] rd_gray;
   logic [PW-1:0] wr_gray_rsync;
   logic [PW-1:0] sync_wr_ptr;
   logic          rd_fire;
   logic [DW-1:0] head;

   assign rd_fire    = rd_en & ~empty;
   assign rd_ptr_nxt = rd_ptr + PW'(1);
   assign head       = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge rd_clk or negedge rd_reset_n) begin
      if (!rd_reset_n) begin
         rd_ptr    <= '0;
         rd_gray   <= '0;
         underflow <= 1'b0;
      end else begin
         if (rd_fire) begin
            rd_ptr  <= rd_ptr_nxt;
            rd_gray <= PW'(bin2gray(ptr_t'(rd_ptr_nxt)));
         end
         if (rd_en && empty) begin
            underflow <= 1'b1;
         end
      end
   end

   gray_sync #(.WIDTH(PW), .STAGES(SYNC_STAGES)) u_wr_ptr_sync (
      .clk   (rd_clk),
      .rst_n (rd_reset_n),
      .d     (wr_gray),
      .q     (wr_gray_rsync)
   );

   always_ff @(posedge rd_clk or negedge rd_reset_n) begin
      if (!rd_reset_n) begin
         sync_wr_ptr <= '0;
      end else begin
         sync_wr_ptr <= PW'(gray2bin(ptr_t'(wr_gray_rsync)));
      end
   end

   assign rd_level = PW'(level_calc(ptr_t'(sync_wr_ptr), ptr_t'(rd_ptr), PW));
   assign empty    = (rd_level == '0);
   assign aempty   = (32'(rd_level) <= AEMPTY_TH);

   // Read port: head shown directly (forced to zero while empty), or a load-on-read register
   if (FWFT != 0) begin : g_fwft
      assign rd_data = empty ? '0 : head;
   end else begin : g_std
      logic [DW-1:0] rd_data_q;

      always_ff @(posedge rd_clk or negedge rd_reset_n) begin
         if (!rd_reset_n) begin
            rd_data_q <= '0;
         end else if (rd_fire) begin
            rd_data_q <= head;
         end
      end

      assign rd_data = rd_data_q;
   end

endmodule

// File: tb/tb_async_fifo_cfg.sv
// Scoreboard bench for async_fifo_cfg: directed flag/latency cases plus long random streams.
`timescale 1ns/100ps
module tb_async_fifo_cfg;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 3;
   localparam int unsigned STREAM_WORDS = 5000;
   localparam int unsigned WR_BUDGET = 30000;
   localparam int unsigned RD_BUDGET = 40000;

   logic wr_clk = 1'b0;
   logic rd_clk = 1'b0;
   logic wr_reset_n = 1'b0;
   logic rd_reset_n = 1'b0;
   realtime wr_half = 5.0;
   realtime rd_half = 13.5;

   // FWFT build
   logic          wr_en = 1'b0, rd_en = 1'b0;
   logic [DW-1:0] wr_data = '0;
   logic [DW-1:0] rd_data;
   logic          full, afull, overflow, empty, aempty, underflow;
   logic [AW:0]   wr_level, rd_level;

   // Registered-read build
   logic          wr_en_s = 1'b0, rd_en_s = 1'b0;
   logic [DW-1:0] wr_data_s = '0;
   logic [DW-1:0] rd_data_s;
   logic          full_s, afull_s, overflow_s, empty_s, aempty_s, underflow_s;
   logic [AW:0]   wr_level_s, rd_level_s;

   async_fifo_cfg #(.DW(DW), .AW(AW), .SYNC_STAGES(2), .FWFT(1), .AFULL_TH(6), .AEMPTY_TH(2)) dut (
      .wr_clk(wr_clk), .wr_reset_n(wr_reset_n), .rd_clk(rd_clk), .rd_reset_n(rd_reset_n),
      .wr_en(wr_en), .wr_data(wr_data), .full(full), .afull(afull), .wr_level(wr_level),
      .overflow(overflow), .rd_en(rd_en), .rd_data(rd_data), .empty(empty), .aempty(aempty),
      .rd_level(rd_level), .underflow(underflow)
   );

   async_fifo_cfg #(.DW(DW), .AW(AW), .SYNC_STAGES(2), .FWFT(0), .AFULL_TH(6), .AEMPTY_TH(2)) dut_std (
      .wr_clk(wr_clk), .wr_reset_n(wr_reset_n), .rd_clk(rd_clk), .rd_reset_n(rd_reset_n),
      .wr_en(wr_en_s), .wr_data(wr_data_s), .full(full_s), .afull(afull_s), .wr_level(wr_level_s),
      .overflow(overflow_s), .rd_en(rd_en_s), .rd_data(rd_data_s), .empty(empty_s), .aempty(aempty_s),
      .rd_level(rd_level_s), .underflow(underflow_s)
   );

   initial forever #(wr_half) wr_clk = ~wr_clk;
   initial forever #(rd_half) rd_clk = ~rd_clk;

   int unsigned   checks = 0;
   int unsigned   passed = 0;
   int unsigned   n_push = 0;
   int unsigned   n_pop  = 0;
   logic [DW-1:0] exp_q [$];
   logic [DW-1:0] exp_word;

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act === req) passed++;
      else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
   endfunction

   // Reference model: an accepted write appends to an ordered queue
   always @(negedge wr_clk) begin
      if (wr_reset_n && wr_en && !full) begin
         exp_q.push_back(wr_data);
         n_push++;
      end
   end

   // Monitor: every word consumed must be the oldest outstanding one
   always @(negedge rd_clk) begin
      if (rd_reset_n && rd_en && !empty) begin
         if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL rd_data: read of 0x%0h with no word outstanding", rd_data);
         end else begin
            exp_word = exp_q.pop_front();
            n_pop++;
            chk("rd_data", 64'(rd_data), 64'(exp_word));
         end
      end
   end

   task automatic do_writes(input int unsigned n, input logic [DW-1:0] first, input bit seq);
      for (int unsigned i = 0; i < n; i++) begin
         @(posedge wr_clk); #1;
         wr_en   = 1'b1;
         wr_data = seq ? first + DW'(i) : DW'($urandom);
      end
      @(posedge wr_clk); #1;
      wr_en = 1'b0;
   endtask

   task automatic do_reads(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) begin
         @(posedge rd_clk); #1;
         rd_en = 1'b1;
      end
      @(posedge rd_clk); #1;
      rd_en = 1'b0;
   endtask

   task automatic settle();
      repeat (5) @(posedge rd_clk);
      repeat (5) @(posedge wr_clk);
      #1;
   endtask

   task automatic run_stream(input int unsigned nwords);
      int unsigned start;
      bit          wr_done;
      start   = n_push;
      wr_done = 1'b0;
      fork
         begin
            for (int unsigned it = 0; it < WR_BUDGET && (n_push - start) < nwords; it++) begin
               @(posedge wr_clk); #1;
               wr_en   = ($urandom_range(3) != 0);
               wr_data = DW'($urandom);
            end
            @(posedge wr_clk); #1;
            wr_en   = 1'b0;
            wr_done = 1'b1;
            chk("stream_words_written", 64'((n_push - start) >= nwords), 64'(1));
         end
         begin
            int unsigned rit;
            rit = 0;
            while (!(wr_done && exp_q.size() == 0) && rit < RD_BUDGET) begin
               @(posedge rd_clk); #1;
               rd_en = ($urandom_range(3) != 0);
               rit++;
            end
            rd_en = 1'b0;
            chk("stream_drained", 64'(exp_q.size()), 64'(0));
         end
      join
      settle();
      chk("stream_empty", 64'(empty), 64'(1));
      chk("stream_rd_level", 64'(rd_level), 64'(0));
      chk("stream_wr_level", 64'(wr_level), 64'(0));
      chk("stream_full", 64'(full), 64'(0));
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset values
      #40;
      chk("rst_full", 64'(full), 64'(0));
      chk("rst_afull", 64'(afull), 64'(0));
      chk("rst_wr_level", 64'(wr_level), 64'(0));
      chk("rst_overflow", 64'(overflow), 64'(0));
      chk("rst_empty", 64'(empty), 64'(1));
      chk("rst_aempty", 64'(aempty), 64'(1));
      chk("rst_rd_level", 64'(rd_level), 64'(0));
      chk("rst_underflow", 64'(underflow), 64'(0));
      chk("rst_std_rd_data", 64'(rd_data_s), 64'(0));
      #60;
      wr_reset_n = 1'b1;
      rd_reset_n = 1'b1;
      settle();

      // Write-to-empty latency: empty must still be set after rd edges 1 and 2
      @(posedge wr_clk); #1;
      wr_en   = 1'b1;
      wr_data = DW'($urandom);
      @(posedge wr_clk);
      fork begin #1; wr_en = 1'b0; end join_none
      for (int k = 1; k <= 3; k++) begin
         @(posedge rd_clk); #0.2;
         chk($sformatf("empty_after_rd_edge%0d", k), 64'(empty), 64'((k < 3) ? 1 : 0));
      end
      do_reads(1);
      settle();

      // Fill to full, then one write too many
      do_writes(8, 32'h1, 1'b1);
      chk("full_after_8", 64'(full), 64'(1));
      chk("overflow_after_8", 64'(overflow), 64'(0));
      chk("wr_level_after_8", 64'(wr_level), 64'(8));
      do_writes(1, 32'h9, 1'b1);
      chk("overflow_after_9", 64'(overflow), 64'(1));
      chk("wr_level_after_9", 64'(wr_level), 64'(8));
      settle();
      chk("rd_level_full", 64'(rd_level), 64'(8));
      chk("aempty_full", 64'(aempty), 64'(0));

      // Drain in order, then one read too many
      do_reads(8);
      chk("empty_after_8_reads", 64'(empty), 64'(1));
      chk("underflow_before_extra", 64'(underflow), 64'(0));
      do_reads(1);
      chk("underflow_after_extra", 64'(underflow), 64'(1));
      chk("nothing_outstanding", 64'(exp_q.size()), 64'(0));
      settle();

      // Almost-full / almost-empty thresholds
      do_writes(5, 32'h0, 1'b0);
      settle();
      chk("wr_level_5", 64'(wr_level), 64'(5));
      chk("afull_at_5", 64'(afull), 64'(0));
      do_writes(1, 32'h0, 1'b0);
      chk("afull_at_6", 64'(afull), 64'(1));
      settle();
      chk("rd_level_6", 64'(rd_level), 64'(6));
      do_reads(3);
      chk("rd_level_3", 64'(rd_level), 64'(3));
      chk("aempty_at_3", 64'(aempty), 64'(0));
      do_reads(1);
      chk("aempty_at_2", 64'(aempty), 64'(1));
      do_reads(2);
      chk("empty_after_drain", 64'(empty), 64'(1));
      settle();
      chk("afull_after_drain", 64'(afull), 64'(0));

      // Registered read port
      @(posedge wr_clk); #1;
      wr_en_s   = 1'b1;
      wr_data_s = 32'hA5;
      @(posedge wr_clk); #1;
      wr_en_s = 1'b0;
      settle();
      chk("std_not_empty", 64'(empty_s), 64'(0));
      chk("std_rd_data_before_read", 64'(rd_data_s), 64'(0));
      @(posedge rd_clk); #1;
      rd_en_s = 1'b1;
      @(posedge rd_clk); #1;
      rd_en_s = 1'b0;
      chk("std_rd_data_loaded", 64'(rd_data_s), 64'(32'hA5));
      chk("std_empty_after_read", 64'(empty_s), 64'(1));
      repeat (4) @(posedge rd_clk);
      #1;
      chk("std_rd_data_held", 64'(rd_data_s), 64'(32'hA5));

      // Long random streams, write side fast then read side fast
      wr_half = 5.0;
      rd_half = 14.75;
      run_stream(STREAM_WORDS);
      wr_half = 15.5;
      rd_half = 5.0;
      run_stream(STREAM_WORDS);
      chk("words_in_equal_words_out", 64'(n_pop), 64'(n_push));

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
